// File: rtl/csr_pkg.sv
// Shared definitions for the Zicsr execute-stage sequencer: funct3 encodings,
// sequencer states, well-known counter addresses and address classification helpers.
package csr_pkg;

    localparam logic [2:0] CSR_OP_RW  = 3'b001;
    localparam logic [2:0] CSR_OP_RS  = 3'b010;
    localparam logic [2:0] CSR_OP_RC  = 3'b011;
    localparam logic [2:0] CSR_OP_RWI = 3'b101;
    localparam logic [2:0] CSR_OP_RSI = 3'b110;
    localparam logic [2:0] CSR_OP_RCI = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } csr_state_e;

    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLE_H   = 12'hC80;
    localparam logic [11:0] CSR_INSTRET_H = 12'hC82;

    // The top two address bits equal to 2'b11 mark the read-only CSR space.
    function automatic logic isReadOnly(input logic [1:0] addrTop);
        return addrTop == 2'b11;
    endfunction

    // funct3 values 000 and 100 are not CSR instructions.
    function automatic logic isValidOp(input logic [2:0] funct3);
        return funct3[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/csr_alu.sv
// Computes the value written back to the CSR from the old value and the operand
// (rs1 data or zero-extended immediate) according to the Zicsr operation.
module csr_alu
    import csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] old_i,
    input  logic [XLEN-1:0] operand_i,
    output logic [XLEN-1:0] wdata_o
);

    always_comb begin
        wdata_o = '0;
        case (funct3_i)
            CSR_OP_RW, CSR_OP_RWI: wdata_o = operand_i;
            CSR_OP_RS, CSR_OP_RSI: wdata_o = old_i | operand_i;
            CSR_OP_RC, CSR_OP_RCI: wdata_o = old_i & ~operand_i;
            default:               wdata_o = '0;
        endcase
    end

endmodule

// File: rtl/csr_exec_unit.sv
// Execute-stage sequencer for Zicsr instructions: accepts one decoded op, reads the
// old CSR value, issues the (legal) write, then returns the old value for rd.
module csr_exec_unit
    import csr_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_funct3,
    input  logic [CSR_AW-1:0] req_addr,
    input  logic [XLEN-1:0]   req_rs1_data,
    input  logic [4:0]        req_uimm,
    input  logic [4:0]        req_rd,
    input  logic              flush,
    output logic              csr_ren,
    output logic [CSR_AW-1:0] csr_raddr,
    input  logic [XLEN-1:0]   csr_rdata,
    output logic              csr_wen,
    output logic [CSR_AW-1:0] csr_waddr,
    output logic [XLEN-1:0]   csr_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [4:0]        rsp_rd,
    output logic [XLEN-1:0]   rsp_data,
    output logic              rsp_illegal,
    output logic              busy
);

    csr_state_e        state_q,   state_d;
    logic [2:0]        funct3_q,  funct3_d;
    logic [CSR_AW-1:0] addr_q,    addr_d;
    logic [4:0]        rd_q,      rd_d;
    logic [XLEN-1:0]   operand_q, operand_d;
    logic [XLEN-1:0]   old_q,     old_d;
    logic              doRead_q,  doRead_d;
    logic              doWrite_q, doWrite_d;
    logic              illegal_q, illegal_d;

    logic              reqFire;
    logic              reqIsRw;
    logic              reqValidOp;
    logic              reqDoRead;
    logic              reqDoWrite;
    logic              reqIllegal;
    logic [XLEN-1:0]   reqOperand;
    logic [XLEN-1:0]   aluWdata;

    // A flush in IDLE blocks acceptance so a squashed instruction never starts.
    assign reqFire    = req_valid && req_ready && !flush;
    assign reqIsRw    = req_funct3[1:0] == 2'b01;
    assign reqValidOp = isValidOp(req_funct3);
    assign reqDoRead  = !(reqIsRw && req_rd == 5'd0);
    assign reqDoWrite = reqValidOp && (reqIsRw || req_uimm != 5'd0);
    assign reqIllegal = !reqValidOp || (reqDoWrite && isReadOnly(req_addr[CSR_AW-1 -: 2]));
    assign reqOperand = req_funct3[2] ? {{(XLEN-5){1'b0}}, req_uimm} : req_rs1_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            funct3_q  <= '0;
            addr_q    <= '0;
            rd_q      <= '0;
            operand_q <= '0;
            old_q     <= '0;
            doRead_q  <= 1'b0;
            doWrite_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            funct3_q  <= funct3_d;
            addr_q    <= addr_d;
            rd_q      <= rd_d;
            operand_q <= operand_d;
            old_q     <= old_d;
            doRead_q  <= doRead_d;
            doWrite_q <= doWrite_d;
            illegal_q <= illegal_d;
        end
    end

    // A flush during WRITE still lets the write commit; only the response is dropped.
    always_comb begin
        state_d   = state_q;
        funct3_d  = funct3_q;
        addr_d    = addr_q;
        rd_d      = rd_q;
        operand_d = operand_q;
        old_d     = old_q;
        doRead_d  = doRead_q;
        doWrite_d = doWrite_q;
        illegal_d = illegal_q;
        csr_ren   = 1'b0;
        csr_wen   = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (reqFire) begin
                    funct3_d  = req_funct3;
                    addr_d    = req_addr;
                    rd_d      = req_rd;
                    operand_d = reqOperand;
                    doRead_d  = reqDoRead;
                    doWrite_d = reqDoWrite;
                    illegal_d = reqIllegal;
                    state_d   = ST_READ;
                end
            end
            ST_READ: begin
                csr_ren = doRead_q;
                old_d   = doRead_q ? csr_rdata : '0;
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (doWrite_q && !illegal_q) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_WRITE: begin
                csr_wen = 1'b1;
                state_d = flush ? ST_IDLE : ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (flush || rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    csr_alu #(
        .XLEN(XLEN)
    ) uAlu (
        .funct3_i (funct3_q),
        .old_i    (old_q),
        .operand_i(operand_q),
        .wdata_o  (aluWdata)
    );

    assign req_ready   = state_q == ST_IDLE;
    assign busy        = state_q != ST_IDLE;
    assign csr_raddr   = addr_q;
    assign csr_waddr   = addr_q;
    assign csr_wdata   = aluWdata;
    assign rsp_rd      = rd_q;
    assign rsp_data    = illegal_q ? '0 : old_q;
    assign rsp_illegal = illegal_q;

endmodule
